// File: rtl/sfm_stream_addrgen.sv
// Stream address generator for the softmax streamers.
// Walks base + up to three strided dimensions on a valid/ready stream.
module sfm_stream_addrgen #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic              req_start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  tot_len_i,
  input  logic [LEN_W-1:0]  d0_len_i,
  input  logic [ADDR_W-1:0] d0_stride_i,
  input  logic [LEN_W-1:0]  d1_len_i,
  input  logic [ADDR_W-1:0] d1_stride_i,
  input  logic [ADDR_W-1:0] d2_stride_i,
  input  logic [1:0]        dim_enable_1h_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              addr_valid_o,
  input  logic              addr_ready_i,
  output logic              ready_start_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, line_q, blk_q;
  logic [ADDR_W-1:0] d0s_q, d1s_q, d2s_q;
  logic [LEN_W-1:0]  c0_q, c1_q, cnt_q;
  logic [LEN_W-1:0]  tot_q, d0l_q, d1l_q;
  logic [1:0]        dim_q;

  logic [LEN_W:0]    c0_inc, c1_inc, cnt_inc;
  logic [ADDR_W-1:0] blk_nxt, line_nxt, beat_nxt;
  logic              hs, start, last, wrap0, wrap1;

  assign c0_inc  = {1'b0, c0_q} + {{LEN_W{1'b0}}, 1'b1};
  assign c1_inc  = {1'b0, c1_q} + {{LEN_W{1'b0}}, 1'b1};
  assign cnt_inc = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};

  // A zero length compares as always-wrapping, i.e. behaves as 1.
  assign wrap0 = dim_q[0] & (c0_inc >= {1'b0, d0l_q});
  assign wrap1 = dim_q[1] & (c1_inc >= {1'b0, d1l_q});
  assign last  = (cnt_inc == {1'b0, tot_q});

  assign blk_nxt  = blk_q + d2s_q;
  assign line_nxt = line_q + d1s_q;
  assign beat_nxt = addr_q + d0s_q;

  assign hs    = addr_valid_o & addr_ready_i;
  assign start = (state_q == IDLE) & enable_i & req_start_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else if (enable_i) begin
      unique case (state_q)
        IDLE: begin
          if (req_start_i) begin
            state_d = (tot_len_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (hs && last) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    addr_valid_o  = 1'b0;
    ready_start_o = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): ready_start_o = 1'b1;
      (state_q == RUN): begin
        addr_valid_o = enable_i;
        busy_o       = 1'b1;
      end
      (state_q == DONE): begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ready_start_o = 1'b0;
    endcase
  end

  assign addr_o = addr_q;

  // Descriptor latch and address walk
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      line_q <= '0;
      blk_q  <= '0;
      d0s_q  <= '0;
      d1s_q  <= '0;
      d2s_q  <= '0;
      c0_q   <= '0;
      c1_q   <= '0;
      cnt_q  <= '0;
      tot_q  <= '0;
      d0l_q  <= '0;
      d1l_q  <= '0;
      dim_q  <= '0;
    end else if (clear_i) begin
      addr_q <= '0;
      line_q <= '0;
      blk_q  <= '0;
      d0s_q  <= '0;
      d1s_q  <= '0;
      d2s_q  <= '0;
      c0_q   <= '0;
      c1_q   <= '0;
      cnt_q  <= '0;
      tot_q  <= '0;
      d0l_q  <= '0;
      d1l_q  <= '0;
      dim_q  <= '0;
    end else if (start && tot_len_i != '0) begin
      addr_q <= base_addr_i;
      line_q <= base_addr_i;
      blk_q  <= base_addr_i;
      d0s_q  <= d0_stride_i;
      d1s_q  <= d1_stride_i;
      d2s_q  <= d2_stride_i;
      c0_q   <= '0;
      c1_q   <= '0;
      cnt_q  <= '0;
      tot_q  <= tot_len_i;
      d0l_q  <= d0_len_i;
      d1l_q  <= d1_len_i;
      dim_q  <= dim_enable_1h_i;
    end else if (hs) begin
      cnt_q <= cnt_inc[LEN_W-1:0];
      if (wrap0) begin
        c0_q <= '0;
        if (wrap1) begin
          c1_q   <= '0;
          blk_q  <= blk_nxt;
          line_q <= blk_nxt;
          addr_q <= blk_nxt;
        end else begin
          c1_q   <= c1_inc[LEN_W-1:0];
          line_q <= line_nxt;
          addr_q <= line_nxt;
        end
      end else begin
        c0_q   <= c0_inc[LEN_W-1:0];
        addr_q <= beat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sfm_stream_addrgen.sv
// Randomized bench for sfm_stream_addrgen.
// Expected addresses come from a closed-form index model.
module tb_sfm_stream_addrgen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        en;
  logic        req;
  logic [31:0] base;
  logic [15:0] tot;
  logic [15:0] d0l;
  logic [31:0] d0s;
  logic [15:0] d1l;
  logic [31:0] d1s;
  logic [31:0] d2s;
  logic [1:0]  dim;
  logic [31:0] addr;
  logic        valid;
  logic        ready;
  logic        rdy_start;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  sfm_stream_addrgen #(
    .ADDR_W(32),
    .LEN_W (16)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear),
    .enable_i       (en),
    .req_start_i    (req),
    .base_addr_i    (base),
    .tot_len_i      (tot),
    .d0_len_i       (d0l),
    .d0_stride_i    (d0s),
    .d1_len_i       (d1l),
    .d1_stride_i    (d1s),
    .d2_stride_i    (d2s),
    .dim_enable_1h_i(dim),
    .addr_o         (addr),
    .addr_valid_o   (valid),
    .addr_ready_i   (ready),
    .ready_start_o  (rdy_start),
    .busy_o         (busy),
    .done_o         (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Address of beat i, from index decomposition.
  function automatic logic [31:0] ref_addr(
    input logic [31:0] b, input int unsigned i,
    input logic [15:0] l0, input logic [31:0] s0,
    input logic [15:0] l1, input logic [31:0] s1,
    input logic [31:0] s2, input logic [1:0] dm);
    int unsigned n0, n1, bt, ln, bk;
    n0 = (l0 == 0) ? 1 : int'(l0);
    n1 = (l1 == 0) ? 1 : int'(l1);
    if (!dm[0]) return b + i * s0;
    bt = i % n0;
    ln = i / n0;
    if (!dm[1]) return b + ln * s1 + bt * s0;
    bk = ln / n1;
    ln = ln % n1;
    return b + bk * s2 + ln * s1 + bt * s0;
  endfunction

  task automatic fill_model(
    input logic [31:0] b, input logic [15:0] t,
    input logic [15:0] l0, input logic [31:0] s0,
    input logic [15:0] l1, input logic [31:0] s1,
    input logic [31:0] s2, input logic [1:0] dm);
    exp_q.delete();
    for (int i = 0; i < int'(t); i++) begin
      exp_q.push_back(ref_addr(b, i, l0, s0, l1, s1, s2, dm));
    end
  endtask

  task automatic start_xfer(
    input logic [31:0] b, input logic [15:0] t,
    input logic [15:0] l0, input logic [31:0] s0,
    input logic [15:0] l1, input logic [31:0] s1,
    input logic [31:0] s2, input logic [1:0] dm);
    @(negedge clk);
    base = b; tot = t; d0l = l0; d0s = s0;
    d1l = l1; d1s = s1; d2s = s2; dim = dm;
    req = 1'b1; en = 1'b1; ready = 1'b0;
    @(negedge clk);
    req  = 1'b0;
    base = $urandom; tot = 16'($urandom);
    d0l  = 16'($urandom); d0s = $urandom;
    d1l  = 16'($urandom); d1s = $urandom;
    d2s  = $urandom; dim = 2'($urandom);
  endtask

  // Drives the stream from the cycle after start until done.
  task automatic run_stream(input bit rnd_rdy, input bit stall,
                            input bit pulse);
    int n = exp_q.size();
    int beats = 0;
    int cyc = 1;
    bit prev_hs = 0, prev_v = 0, got_done = 0;
    logic [31:0] prev_a = '0;
    while (cyc <= 500) begin
      en    = !(stall && cyc >= 4 && cyc < 9);
      ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (done) begin
        chk("beat_count", beats, n);
        if (n == 0) chk("done_lat0", cyc, 1);
        else chk("done_lat", prev_hs, 1);
        chk("done_valid", valid, 0);
        got_done = 1;
        req = 1'b0;
        en  = 1'b1;
        break;
      end
      if (prev_v && !prev_hs && valid) chk("addr_hold", addr, prev_a);
      chk("valid_en", valid, en);
      chk("busy_run", busy, 1);
      if (valid && ready) begin
        if (beats < n) chk("addr", addr, exp_q[beats]);
        else chk("extra_beat", beats + 1, n);
        beats++;
      end
      prev_hs = valid && ready;
      prev_v  = valid;
      prev_a  = addr;
      req = pulse ? ($urandom_range(0, 3) == 0) : 1'b0;
      cyc++;
      @(negedge clk);
    end
    req = 1'b0;
    en  = 1'b1;
    chk("done_seen", got_done, 1);
    @(negedge clk);
    #1;
    chk("rdy_after", rdy_start, 1);
    chk("done_pulse", done, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdy"}, rdy_start, 1);
  endtask

  initial begin
    logic [31:0] b, s0, s1, s2;
    logic [15:0] t, l0, l1;
    logic [1:0]  dm;
    rst_n = 1'b0; clear = 1'b0; en = 1'b1; req = 1'b0; ready = 1'b0;
    base = '0; tot = '0; d0l = '0; d0s = '0;
    d1l = '0; d1s = '0; d2s = '0; dim = '0;
    #3;
    chk_reset_outs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Linear stream
    fill_model(32'h0, 16, 0, 32'h10, 0, 0, 0, 2'b00);
    start_xfer(32'h0, 16, 0, 32'h10, 0, 0, 0, 2'b00);
    run_stream(0, 0, 0);

    // Two-dimensional wrap
    exp_q = '{32'h100, 32'h104, 32'h108, 32'h140, 32'h144, 32'h148};
    start_xfer(32'h100, 6, 3, 32'h4, 0, 32'h40, 0, 2'b01);
    run_stream(0, 0, 0);

    // Three-dimensional wrap
    exp_q = '{32'h000, 32'h001, 32'h010, 32'h011,
              32'h100, 32'h101, 32'h110, 32'h111};
    start_xfer(32'h0, 8, 2, 32'h1, 2, 32'h10, 32'h100, 2'b11);
    run_stream(0, 0, 0);

    // Backpressure, enable stall, ignored start pulses
    fill_model(32'h4000, 20, 3, 32'h8, 2, 32'h80, 32'h1000, 2'b11);
    start_xfer(32'h4000, 20, 3, 32'h8, 2, 32'h80, 32'h1000, 2'b11);
    run_stream(1, 1, 1);

    // Zero length
    exp_q.delete();
    start_xfer(32'h1234, 0, 0, 32'h4, 0, 0, 0, 2'b00);
    run_stream(0, 0, 0);

    // Address wrap-around
    exp_q = '{32'hFFFF_FFF0, 32'h0, 32'h10, 32'h20};
    start_xfer(32'hFFFF_FFF0, 4, 0, 32'h10, 0, 0, 0, 2'b00);
    run_stream(1, 0, 1);

    // Clear on the 3rd handshake
    start_xfer(32'h2000, 16, 0, 32'h4, 0, 0, 0, 2'b00);
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("clr_pre_addr", addr, 32'h2008);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk_reset_outs("clr");
    @(negedge clk);
    #1;
    chk("clr_no_done", done, 0);
    fill_model(32'h3000, 5, 0, 32'h4, 0, 0, 0, 2'b00);
    start_xfer(32'h3000, 5, 0, 32'h4, 0, 0, 0, 2'b00);
    run_stream(1, 0, 0);

    // Async reset mid-run
    start_xfer(32'h5000, 16, 0, 32'h4, 0, 0, 0, 2'b00);
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    fill_model(32'h6000, 6, 2, 32'h4, 0, 32'h100, 0, 2'b01);
    start_xfer(32'h6000, 6, 2, 32'h4, 0, 32'h100, 0, 2'b01);
    run_stream(0, 0, 0);

    // Random descriptors
    for (int k = 0; k < 10; k++) begin
      b  = $urandom;
      t  = 16'($urandom_range(0, 24));
      l0 = 16'($urandom_range(0, 4));
      l1 = 16'($urandom_range(0, 3));
      s0 = $urandom;
      s1 = $urandom;
      s2 = $urandom;
      dm = 2'($urandom_range(0, 3));
      fill_model(b, t, l0, s0, l1, s1, s2, dm);
      start_xfer(b, t, l0, s0, l1, s1, s2, dm);
      run_stream(1, (t > 12), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
